// File: rtl/half_vector_to_stream.sv
// Serialiser: takes a LENGTH-word vector in one handshake and streams it out
// one word per valid/ready transfer, index 0 first, with one pending vector buffered.
module half_vector_to_stream #(
    parameter int BITS   = 16,
    parameter int LENGTH = 10,
    localparam int IW    = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] y [LENGTH],
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] x,
    output logic            out_last,
    output logic [IW-1:0]   out_index
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [IW-1:0] LAST = IW'(LENGTH - 1);

    state_t          state, state_n;
    logic [IW-1:0]   count, count_n;
    logic            pend_full, pend_n;
    logic [BITS-1:0] a_buf [LENGTH];
    logic [BITS-1:0] p_buf [LENGTH];
    logic            load_a_y, load_a_p, load_p;
    logic            accept, xfer, at_last;

    assign accept  = in_valid & ~pend_full;
    assign xfer    = (state == SEND) & out_ready;
    assign at_last = (count == LAST);

    always_comb begin
        state_n  = state;
        count_n  = count;
        pend_n   = pend_full;
        load_a_y = 1'b0;
        load_a_p = 1'b0;
        load_p   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load_a_y = 1'b1;
                    count_n  = '0;
                    state_n  = SEND;
                end
            end
            SEND: begin
                if (xfer && at_last) begin
                    // Refill straight from pending or input so the stream stays gapless.
                    count_n = '0;
                    if (pend_full) begin
                        load_a_p = 1'b1;
                        pend_n   = accept;
                        load_p   = accept;
                    end else if (accept) begin
                        load_a_y = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (xfer) count_n = count + 1'b1;
                    if (accept) begin
                        load_p = 1'b1;
                        pend_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            count     <= '0;
            pend_full <= 1'b0;
            for (int unsigned i = 0; i < LENGTH; i++) begin
                a_buf[i] <= '0;
                p_buf[i] <= '0;
            end
        end else begin
            state     <= state_n;
            count     <= count_n;
            pend_full <= pend_n;
            for (int unsigned i = 0; i < LENGTH; i++) begin
                if (load_a_y)      a_buf[i] <= y[i];
                else if (load_a_p) a_buf[i] <= p_buf[i];
                if (load_p)        p_buf[i] <= y[i];
            end
        end
    end

    assign in_ready  = ~pend_full;
    assign out_valid = (state == SEND);
    assign x         = out_valid ? a_buf[count] : '0;
    assign out_last  = out_valid & at_last;
    assign out_index = count;

endmodule
